// File: rtl/sprite_ram_loader_pkg.sv
// Shared types and geometry for the sprite RAM loader: pixel type, FSM states,
// sprite dimensions and the (row, col) -> RAM address helper.
package sprite_pkg;

   localparam int SPRITE_W   = 32;
   localparam int SPRITE_H   = 32;
   localparam int PIX_BITS   = 2;
   localparam int COL_BITS   = $clog2(SPRITE_W);
   localparam int ROW_BITS   = $clog2(SPRITE_H);
   localparam int ADDR_BITS  = COL_BITS + ROW_BITS;
   localparam int DEPTH      = SPRITE_W * SPRITE_H;
   localparam int COORD_BITS = 10;

   typedef logic [PIX_BITS-1:0] pix_t;

   localparam pix_t PIX_TRANSPARENT = 2'b00;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DONE = 2'd2
   } loader_state_t;

   // Raster-order address: row in the high bits, column in the low bits.
   function automatic logic [ADDR_BITS-1:0] pix_addr(input logic [ROW_BITS-1:0] row,
                                                     input logic [COL_BITS-1:0] col);
      return {row, col};
   endfunction

endpackage

// File: rtl/sprite_ram_loader_if.sv
// Pixel-stream handshake and sprite read port shared by the loader and its users.
// The mirror line exists only when SPRITE_MIRROR_EN is defined.
interface sprite_ram_loader_if;
   import sprite_pkg::*;

   logic                  start;
   logic                  pix_valid;
   pix_t                  pix_data;
   logic                  pix_ready;
   logic                  busy;
   logic                  done;
   logic [COORD_BITS-1:0] horz;
   logic [COORD_BITS-1:0] vert;
   pix_t                  draw_code;
`ifdef SPRITE_MIRROR_EN
   logic                  mirror;

   modport master (output start, pix_valid, pix_data, horz, vert, mirror,
                   input  pix_ready, busy, done, draw_code);
   modport slave  (input  start, pix_valid, pix_data, horz, vert, mirror,
                   output pix_ready, busy, done, draw_code);
`else
   modport master (output start, pix_valid, pix_data, horz, vert,
                   input  pix_ready, busy, done, draw_code);
   modport slave  (input  start, pix_valid, pix_data, horz, vert,
                   output pix_ready, busy, done, draw_code);
`endif

endinterface

// File: rtl/sprite_ram_loader_ram_2p.sv
// Sprite pixel store: one write port, one registered read port, read-before-write,
// asynchronously cleared to transparent.
module sprite_ram_2p
   import sprite_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 we,
   input  logic [ADDR_BITS-1:0] waddr,
   input  pix_t                 wdata,
   input  logic                 rd_en,
   input  logic [ADDR_BITS-1:0] raddr,
   output pix_t                 rdata
);

   pix_t mem [DEPTH];
   pix_t rdata_r;

   // Storage array: cleared on reset, written on accepted pixels.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= PIX_TRANSPARENT;
         end
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Read register: sees pre-write contents; out-of-range reads return transparent.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata_r <= PIX_TRANSPARENT;
      end else if (rd_en) begin
         rdata_r <= mem[raddr];
      end else begin
         rdata_r <= PIX_TRANSPARENT;
      end
   end

   assign rdata = rdata_r;

endmodule

// File: rtl/sprite_ram_loader.sv
// Loads a raster-ordered stream of pixel codes into the sprite RAM and serves
// (vert, horz) lookups. Define SPRITE_MIRROR_EN for horizontally mirrored reads.
module sprite_ram_loader
   import sprite_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   sprite_ram_loader_if.slave bus
);

   loader_state_t         state_r;
   loader_state_t         state_s;
   logic [COL_BITS-1:0]   col_r;
   logic [ROW_BITS-1:0]   row_r;
   logic                  pix_ready_r;
   logic                  busy_r;
   logic                  done_r;
   logic                  pix_ready_s;
   logic                  busy_s;
   logic                  done_s;
   logic                  xfer_s;
   logic                  last_col_s;
   logic                  last_row_s;
   logic                  in_range_s;
   logic [COL_BITS-1:0]   rd_col_s;
   logic [ADDR_BITS-1:0]  waddr_s;
   logic [ADDR_BITS-1:0]  raddr_s;
   pix_t                  draw_code_s;

   assign xfer_s     = pix_ready_r & bus.pix_valid;
   assign last_col_s = (col_r == COL_BITS'(SPRITE_W - 1));
   assign last_row_s = (row_r == ROW_BITS'(SPRITE_H - 1));

   // State and registered status outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= IDLE;
         pix_ready_r <= 1'b0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
      end else begin
         state_r     <= state_s;
         pix_ready_r <= pix_ready_s;
         busy_r      <= busy_s;
         done_r      <= done_s;
      end
   end

   // Next-state logic; start is honoured only from IDLE.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (bus.start) state_s = LOAD;
            else           state_s = IDLE;
         end
         LOAD: begin
            if (xfer_s && last_col_s && last_row_s) state_s = DONE;
            else                                    state_s = LOAD;
         end
         DONE:    state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // Status outputs decoded from the upcoming state so they register in step with it.
   always_comb begin
      pix_ready_s = 1'b0;
      busy_s      = 1'b0;
      done_s      = 1'b0;
      case (state_s)
         IDLE: begin
         end
         LOAD: begin
            pix_ready_s = 1'b1;
            busy_s      = 1'b1;
         end
         DONE:    done_s = 1'b1;
         default: done_s = 1'b0;
      endcase
   end

   // Raster write pointer: cleared on accepted start, advanced per transfer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         col_r <= COL_BITS'(0);
         row_r <= ROW_BITS'(0);
      end else if ((state_r == IDLE) && bus.start) begin
         col_r <= COL_BITS'(0);
         row_r <= ROW_BITS'(0);
      end else if (xfer_s) begin
         if (last_col_s) begin
            col_r <= COL_BITS'(0);
            row_r <= last_row_s ? ROW_BITS'(0) : row_r + ROW_BITS'(1);
         end else begin
            col_r <= col_r + COL_BITS'(1);
         end
      end
   end

   // Read address decode; range is judged on the raw horz before any mirroring.
   always_comb begin
      in_range_s = (bus.horz < COORD_BITS'(SPRITE_W)) && (bus.vert < COORD_BITS'(SPRITE_H));
      rd_col_s   = bus.horz[COL_BITS-1:0];
`ifdef SPRITE_MIRROR_EN
      if (bus.mirror) rd_col_s = COL_BITS'(SPRITE_W - 1) - bus.horz[COL_BITS-1:0];
      else            rd_col_s = bus.horz[COL_BITS-1:0];
`endif
   end

   assign waddr_s = pix_addr(row_r, col_r);
   assign raddr_s = pix_addr(bus.vert[ROW_BITS-1:0], rd_col_s);

   sprite_ram_2p u_ram (
      .clk   (clk),
      .rst   (rst),
      .we    (xfer_s),
      .waddr (waddr_s),
      .wdata (bus.pix_data),
      .rd_en (in_range_s),
      .raddr (raddr_s),
      .rdata (draw_code_s)
   );

   assign bus.pix_ready = pix_ready_r;
   assign bus.busy      = busy_r;
   assign bus.done      = done_r;
   assign bus.draw_code = draw_code_s;

endmodule
